// File: rtl/fifo_sched_pkg.sv
// Shared types and default sizes for the FIFO drain scheduler.
package fifo_sched_pkg;

    localparam int unsigned N_BLOCKS      = 24;
    localparam int unsigned ID_W          = 5;
    localparam int unsigned SLOT_BITS_DEF = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/fifo_drain_sched_rr_pick.sv
// Wrap-around priority finder: first set mask bit after i_last, searching ids
// last+1..N then 1..last. Ids are 1-based; i_last is expected in 1..N.
module rr_pick #(
    parameter int unsigned N    = 24,
    parameter int unsigned ID_W = 5
) (
    input  logic [N:1]      i_mask,
    input  logic [ID_W-1:0] i_last,
    output logic [ID_W-1:0] o_id,
    output logic            o_found
);

    logic [ID_W-1:0] w_cand;

    // Walk from farthest to nearest so the nearest hit is the last assignment.
    always_comb begin
        o_id    = '0;
        o_found = 1'b0;
        w_cand  = '0;
        for (int k = int'(N); k >= 1; k--) begin
            w_cand = ID_W'((int'(i_last) + k - 1) % int'(N) + 1);
            if (i_mask[w_cand]) begin
                o_id    = w_cand;
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_drain_sched.sv
// Round-robin drain scheduler sharing the RMII readout path among N result FIFOs.
// Optional SCHED_OFLOW_PRIO_EN: overflowed non-empty FIFOs win the scan first.
module fifo_drain_sched #(
    parameter int unsigned N         = fifo_sched_pkg::N_BLOCKS,
    parameter int unsigned SLOT_BITS = fifo_sched_pkg::SLOT_BITS_DEF,
    parameter int unsigned ID_W      = fifo_sched_pkg::ID_W
) (
    input  logic            mii_clk,
    input  logic            mii_rst_n,
    input  logic            pkt_start,
    input  logic            sink_ready,
    input  logic [N:1]      fifo_empty,
    input  logic [N:1]      fifo_oflow,
    input  logic [N:1]      fifo_bits,
    output logic [N:1]      fifo_req,
    output logic            out_bit,
    output logic            out_valid,
    output logic [ID_W-1:0] sel_id,
    output logic            sel_oflow,
    output logic            sel_short,
    output logic            pkt_done,
    output logic            busy
);

    import fifo_sched_pkg::*;

    localparam int unsigned CNT_W = $clog2(SLOT_BITS + 1);

    sched_state_t    r_state;
    sched_state_t    w_next;
    logic [ID_W-1:0] r_sel_id;
    logic [ID_W-1:0] r_last;
    logic            r_sel_oflow;
    logic            r_sel_short;
    logic            r_pend;
    logic [CNT_W-1:0] r_cnt;

    logic            w_req;
    logic            w_short;
    logic            w_found;
    logic            w_sel_empty;
    logic [ID_W-1:0] w_pick_id;
    logic [N:1]      w_avail;
    logic [ID_W-1:0] w_rr_id;
    logic            w_rr_found;

    assign w_avail = ~fifo_empty;

    rr_pick #(.N(N), .ID_W(ID_W)) u_pick_rr (
        .i_mask  (w_avail),
        .i_last  (r_last),
        .o_id    (w_rr_id),
        .o_found (w_rr_found)
    );

`ifdef SCHED_OFLOW_PRIO_EN
    logic [N:1]      w_of_mask;
    logic [ID_W-1:0] w_of_id;
    logic            w_of_found;

    assign w_of_mask = fifo_oflow & w_avail;

    rr_pick #(.N(N), .ID_W(ID_W)) u_pick_of (
        .i_mask  (w_of_mask),
        .i_last  (r_last),
        .o_id    (w_of_id),
        .o_found (w_of_found)
    );

    assign w_pick_id = w_of_found ? w_of_id : w_rr_id;
    assign w_found   = w_of_found | w_rr_found;
`else
    assign w_pick_id = w_rr_id;
    assign w_found   = w_rr_found;
`endif

    assign w_sel_empty = fifo_empty[r_sel_id];

    always_ff @(posedge mii_clk or negedge mii_rst_n) begin
        if (!mii_rst_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // Next state plus the per-cycle read strobe decision.
    always_comb begin
        w_next  = r_state;
        w_req   = 1'b0;
        w_short = 1'b0;
        case (r_state)
            S_IDLE:  if (pkt_start) w_next = S_SCAN;
            S_SCAN:  w_next = w_found ? S_DRAIN : S_DONE;
            S_DRAIN: begin
                // Any bit requested last cycle is presented now, so leaving here loses nothing.
                if (r_cnt == CNT_W'(SLOT_BITS)) begin
                    w_next = S_DONE;
                end else if (w_sel_empty) begin
                    w_next  = S_DONE;
                    w_short = 1'b1;
                end else begin
                    w_req = sink_ready;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge mii_clk or negedge mii_rst_n) begin
        if (!mii_rst_n) begin
            r_sel_id    <= '0;
            r_last      <= ID_W'(N);
            r_sel_oflow <= 1'b0;
            r_sel_short <= 1'b0;
            r_pend      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_pend <= w_req;
            case (r_state)
                S_SCAN: begin
                    r_cnt       <= '0;
                    r_sel_short <= 1'b0;
                    if (w_found) begin
                        r_sel_id    <= w_pick_id;
                        r_sel_oflow <= fifo_oflow[w_pick_id];
                        r_last      <= w_pick_id;
                    end else begin
                        r_sel_id    <= '0;
                        r_sel_oflow <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (w_req)   r_cnt       <= r_cnt + CNT_W'(1);
                    if (w_short) r_sel_short <= 1'b1;
                end
                S_DONE: begin
                    r_sel_id    <= '0;
                    r_sel_oflow <= 1'b0;
                    r_sel_short <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Strobe is decoded from the state register so reset forces it low at once.
    assign fifo_req  = w_req ? (N'(1) << (r_sel_id - ID_W'(1))) : '0;
    assign out_bit   = r_pend & fifo_bits[r_sel_id];
    assign out_valid = r_pend;
    assign sel_id    = r_sel_id;
    assign sel_oflow = r_sel_oflow;
    assign sel_short = r_sel_short;
    assign pkt_done  = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_fifo_drain_sched.sv
// Directed self-checking bench for fifo_drain_sched with a behavioural FIFO array.
`timescale 1ns/1ps
module tb_fifo_drain_sched;

    localparam int unsigned N    = 24;
    localparam int unsigned SLOT = 64;
    localparam int unsigned IDW  = 5;
`ifdef SCHED_OFLOW_PRIO_EN
    localparam int PRIO = 1;
`else
    localparam int PRIO = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           pkt_start;
    logic           sink_ready;
    logic [N:1]     fifo_empty;
    logic [N:1]     fifo_oflow;
    logic [N:1]     fifo_bits;
    logic [N:1]     fifo_req;
    logic           out_bit;
    logic           out_valid;
    logic [IDW-1:0] sel_id;
    logic           sel_oflow;
    logic           sel_short;
    logic           pkt_done;
    logic           busy;

    int level [1:N];
    int rd    [1:N];
    int cons  [1:N];
    int cur_id    = 0;
    int tot_bits  = 0;
    int tot_derr  = 0;
    int tot_rbad  = 0;
    int n_chk     = 0;
    int n_bad     = 0;

    fifo_drain_sched #(.N(N), .SLOT_BITS(SLOT), .ID_W(IDW)) dut (
        .mii_clk    (clk),
        .mii_rst_n  (rst_n),
        .pkt_start  (pkt_start),
        .sink_ready (sink_ready),
        .fifo_empty (fifo_empty),
        .fifo_oflow (fifo_oflow),
        .fifo_bits  (fifo_bits),
        .fifo_req   (fifo_req),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .sel_id     (sel_id),
        .sel_oflow  (sel_oflow),
        .sel_short  (sel_short),
        .pkt_done   (pkt_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic data_fn(input int id, input int k);
        int v;
        v = id * 37 + k * 11 + k / 3;
        return v[0] ^ v[2];
    endfunction

    always_comb begin
        for (int i = 1; i <= int'(N); i++) fifo_empty[i] = (rd[i] >= level[i]);
    end

    // FIFO model: a strobe at one edge puts the next stored bit on the line for the following cycle.
    always @(posedge clk) begin
        for (int i = 1; i <= int'(N); i++) begin
            if (fifo_req[i]) begin
                fifo_bits[i] <= data_fn(i, rd[i]);
                rd[i]        <= rd[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [N:1] m;
        m = (cur_id > 0) ? (N'(1) << (cur_id - 1)) : '0;
        if (fifo_req != '0 && fifo_req != m) tot_rbad++;
        if (out_valid) begin
            tot_bits++;
            if (cur_id < 1) begin
                tot_derr++;
            end else begin
                if (out_bit !== data_fn(cur_id, cons[cur_id])) tot_derr++;
                cons[cur_id]++;
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_level(input int id, input int n);
        level[id] = rd[id] + n;
    endtask

    task automatic clear_all();
        for (int i = 1; i <= int'(N); i++) level[i] = rd[i];
    endtask

    // Issue one request and check the whole slot; caller sits at posedge+1.
    task automatic run_slot(input string tag, input int exp_id, input int exp_n,
                            input int exp_short, input int exp_oflow, input int exp_lat);
        int b0, d0, r0, cyc;
        cur_id = exp_id;
        b0 = tot_bits;
        d0 = tot_derr;
        r0 = tot_rbad;
        pkt_start = 1'b1;
        @(posedge clk); #1 pkt_start = 1'b0;
        cyc = 1;
        while (pkt_done !== 1'b1 && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".done"}, int'(pkt_done), 1);
        if (exp_lat > 0) chk({tag, ".lat"}, cyc, exp_lat);
        chk({tag, ".id"},    int'(sel_id), exp_id);
        chk({tag, ".busy"},  int'(busy), 1);
        chk({tag, ".short"}, int'(sel_short), exp_short);
        chk({tag, ".oflow"}, int'(sel_oflow), exp_oflow);
        chk({tag, ".bits"},  tot_bits - b0, exp_n);
        chk({tag, ".data"},  tot_derr - d0, 0);
        chk({tag, ".req"},   tot_rbad - r0, 0);
        @(posedge clk); #1;
        chk({tag, ".idle"}, int'(busy) + int'(sel_id) + int'(sel_short) + int'(sel_oflow), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        pkt_start  = 1'b0;
        sink_ready = 1'b1;
        fifo_oflow = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy",  int'(busy), 0);
        chk("rst.done",  int'(pkt_done), 0);
        chk("rst.valid", int'(out_valid), 0);
        chk("rst.id",    int'(sel_id), 0);
        chk("rst.req",   int'(fifo_req), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nothing to serve.
        run_slot("t1", 0, 0, 0, 0, 2);

        // Round robin between 3 and 7, starting from id 1 after reset.
        set_level(3, 200);
        set_level(7, 100);
        run_slot("t2a", 3, int'(SLOT), 0, 0, int'(SLOT) + 3);
        run_slot("t2b", 7, int'(SLOT), 0, 0, int'(SLOT) + 3);
        run_slot("t2c", 3, int'(SLOT), 0, 0, int'(SLOT) + 3);

        // Short slot.
        clear_all();
        set_level(5, 10);
        run_slot("t4", 5, 10, 1, 0, 0);

        // Stalled sink plus a dropped request while busy.
        clear_all();
        set_level(6, int'(SLOT));
        fork
            run_slot("t5", 6, int'(SLOT), 0, 0, 0);
            begin
                for (int r = 0; r < 12; r++) begin
                    for (int p = 0; p < 4; p++) begin
                        sink_ready = (p == 1 || p == 2) ? 1'b0 : 1'b1;
                        @(posedge clk); #1;
                    end
                end
                sink_ready = 1'b1;
            end
            begin
                repeat (10) @(posedge clk);
                #1 pkt_start = 1'b1;
                @(posedge clk); #1 pkt_start = 1'b0;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        chk("t5.drop", int'(busy), 0);

        // Reset in the middle of a drain.
        clear_all();
        set_level(10, int'(SLOT));
        cur_id = 10;
        pkt_start = 1'b1;
        @(posedge clk); #1 pkt_start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("rst.req_live", int'(fifo_req), 1 << 9);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.req_async", int'(fifo_req), 0);
        chk("rst.busy_async", int'(busy), 0);
        chk("rst.valid_async", int'(out_valid), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        clear_all();

        // Pointer back at N: only 24 is full, then 1 joins.
        set_level(24, 100);
        run_slot("t3a", 24, int'(SLOT), 0, 0, int'(SLOT) + 3);
        set_level(1, 100);
        run_slot("t3b", 1, int'(SLOT), 0, 0, int'(SLOT) + 3);

        // Overflow priority and oflow snapshot.
        clear_all();
        set_level(2, int'(SLOT));
        run_slot("t6a", 2, int'(SLOT), 0, 0, int'(SLOT) + 3);
        clear_all();
        set_level(4, int'(SLOT));
        set_level(9, int'(SLOT));
        fifo_oflow[9] = 1'b1;
        fork
            run_slot("t6b", PRIO ? 9 : 4, int'(SLOT), 0, PRIO ? 1 : 0, int'(SLOT) + 3);
            begin
                repeat (5) @(posedge clk);
                #1 fifo_oflow[4] = 1'b1;
            end
        join
        run_slot("t6c", PRIO ? 4 : 9, int'(SLOT), 0, 1, int'(SLOT) + 3);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
